// File: rtl/reg_file_wr_arb_if.sv
// Write-port bus between the four register-file writers and reg_file_wr_arb.
// Requesters drive the master side; the arbiter is the slave.
interface reg_file_wr_arb_if #(
    parameter int unsigned W = 7
);
    logic [3:0]         req;
    logic [3:0]         lock;
    logic [15:0]        waddr;
    logic [4*(W+1)-1:0] wdata;
    logic [3:0]         ack;
    logic               reg_ena;
    logic [3:0]         rd;
    logic [W:0]         data;
    logic [1:0]         gnt_id;
    logic [15:0]        wr_count;

    modport master (
        output req, lock, waddr, wdata,
        input  ack, reg_ena, rd, data, gnt_id, wr_count
    );

    modport slave (
        input  req, lock, waddr, wdata,
        output ack, reg_ena, rd, data, gnt_id, wr_count
    );
endinterface

// File: rtl/reg_file_wr_arb.sv
// Round-robin arbiter for the register file's single write port, registered write outputs.
// Optional burst lock (LOCK_MAX consecutive grants to a locking requester) with `RF_ARB_LOCK_EN.
module reg_file_wr_arb #(
    parameter int unsigned W        = 7,
    parameter int unsigned LOCK_MAX = 4
) (
    input  logic             clk,
    input  logic             reset,
    reg_file_wr_arb_if.slave bus
);
    localparam int unsigned DW = W + 1;

    logic [1:0]  last_q, last_d;
    logic        reg_ena_q, reg_ena_d;
    logic [3:0]  rd_q, rd_d;
    logic [W:0]  data_q, data_d;
    logic [1:0]  gnt_id_q, gnt_id_d;
    logic [15:0] wr_count_q, wr_count_d;

    logic        rr_valid;
    logic [1:0]  rr_idx;
    logic [1:0]  cand;
    logic        grant_valid;
    logic [1:0]  grant_idx;
    logic [3:0]  sel_addr;
    logic [W:0]  sel_data;

    // Rotation search from last+1; k = 4 wraps back onto last itself.
    always_comb begin
        rr_valid = 1'b0;
        rr_idx   = last_q;
        cand     = '0;
        for (int unsigned k = 1; k <= 4; k++) begin
            cand = last_q + 2'(k);
            if (!rr_valid && bus.req[cand]) begin
                rr_valid = 1'b1;
                rr_idx   = cand;
            end
        end
    end

`ifdef RF_ARB_LOCK_EN
    logic [3:0] burst_q, burst_d;
    logic       hold;

    always_comb begin
        hold        = bus.req[last_q] && bus.lock[last_q] &&
                      (burst_q < 4'(LOCK_MAX - 1));
        grant_valid = hold || rr_valid;
        grant_idx   = hold ? last_q : rr_idx;
        burst_d     = hold ? burst_q + 4'd1 : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end
`else
    localparam logic [3:0] LockMaxBits = 4'(LOCK_MAX);
    logic unused_lock;
    assign unused_lock = ^{bus.lock, LockMaxBits};

    always_comb begin
        grant_valid = rr_valid;
        grant_idx   = rr_idx;
    end
`endif

    always_comb begin
        sel_addr   = bus.waddr[4*grant_idx +: 4];
        sel_data   = bus.wdata[DW*grant_idx +: DW];
        last_d     = last_q;
        rd_d       = rd_q;
        data_d     = data_q;
        gnt_id_d   = gnt_id_q;
        reg_ena_d  = 1'b0;
        wr_count_d = wr_count_q + {15'd0, reg_ena_q};
        if (grant_valid) begin
            last_d    = grant_idx;
            rd_d      = sel_addr;
            data_d    = sel_data;
            gnt_id_d  = grant_idx;
            // Register 0 is hard-wired zero: take the request but drop the write.
            reg_ena_d = (sel_addr != '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q     <= 2'd3;
            reg_ena_q  <= 1'b0;
            rd_q       <= '0;
            data_q     <= '0;
            gnt_id_q   <= '0;
            wr_count_q <= '0;
        end else begin
            last_q     <= last_d;
            reg_ena_q  <= reg_ena_d;
            rd_q       <= rd_d;
            data_q     <= data_d;
            gnt_id_q   <= gnt_id_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign bus.ack      = (reset && grant_valid) ? (4'b0001 << grant_idx) : '0;
    assign bus.reg_ena  = reg_ena_q;
    assign bus.rd       = rd_q;
    assign bus.data     = data_q;
    assign bus.gnt_id   = gnt_id_q;
    assign bus.wr_count = wr_count_q;
endmodule

// File: tb/tb_reg_file_wr_arb.sv
// Self-checking bench for reg_file_wr_arb: fixed vectors, corner sequences, random vs. model.
module tb_reg_file_wr_arb;
    localparam int unsigned W        = 7;
    localparam int unsigned LOCK_MAX = 4;
    localparam int          DW       = W + 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    reg_file_wr_arb_if #(.W(W)) bus();

    reg_file_wr_arb #(.W(W), .LOCK_MAX(LOCK_MAX)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int         m_last, m_burst, m_cnt, m_gnt;
    bit         m_ena;
    logic [3:0] m_rd;
    logic [W:0] m_data;

    typedef struct {
        logic [3:0]    req;
        logic [15:0]   waddr;
        logic [4*DW-1:0] wdata;
        logic [3:0]    ack;
        logic          ena;
        logic [3:0]    rd;
        logic [W:0]    data;
        logic [1:0]    gnt;
        logic [15:0]   cnt;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_last  = 3;
        m_burst = 0;
        m_cnt   = 0;
        m_gnt   = 0;
        m_ena   = 0;
        m_rd    = '0;
        m_data  = '0;
    endfunction

    function automatic int model_pick(input logic [3:0] r, input logic [3:0] l, output bit held);
        held = 0;
`ifdef RF_ARB_LOCK_EN
        if (r[m_last] && l[m_last] && m_burst < LOCK_MAX - 1) begin
            held = 1;
            return m_last;
        end
`else
        if (l === 4'hx) held = 0;
`endif
        for (int k = 1; k <= 4; k++)
            if (r[(m_last + k) % 4]) return (m_last + k) % 4;
        return -1;
    endfunction

    function automatic logic [3:0] model_ack(input logic [3:0] r, input logic [3:0] l);
        bit h;
        int w;
        w = model_pick(r, l, h);
        return (w < 0) ? 4'b0000 : 4'(1 << w);
    endfunction

    function automatic void model_edge(input logic [3:0] r, input logic [3:0] l,
                                       input logic [15:0] a, input logic [4*DW-1:0] d);
        bit held;
        int w;
        w = model_pick(r, l, held);
        if (m_ena) m_cnt = (m_cnt + 1) % 65536;
        if (w >= 0) begin
            m_last  = w;
            m_gnt   = w;
            m_rd    = a[4*w +: 4];
            m_data  = d[DW*w +: DW];
            m_ena   = (a[4*w +: 4] != 0);
            m_burst = held ? m_burst + 1 : 0;
        end else begin
            m_ena   = 0;
            m_burst = 0;
        end
    endfunction

    task automatic drive(input logic [3:0] r, input logic [3:0] l,
                         input logic [15:0] a, input logic [4*DW-1:0] d);
        bus.req   = r;
        bus.lock  = l;
        bus.waddr = a;
        bus.wdata = d;
    endtask

    task automatic check_regs();
        check("reg_ena",  32'(bus.reg_ena),  32'(m_ena));
        check("rd",       32'(bus.rd),       32'(m_rd));
        check("data",     32'(bus.data),     32'(m_data));
        check("gnt_id",   32'(bus.gnt_id),   32'(m_gnt));
        check("wr_count", 32'(bus.wr_count), 32'(m_cnt));
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic run_cycle(input logic [3:0] r, input logic [3:0] l,
                             input logic [15:0] a, input logic [4*DW-1:0] d, input bit chk);
        drive(r, l, a, d);
        #1;
        if (chk) check("ack", 32'(bus.ack), 32'(model_ack(r, l)));
        model_edge(r, l, a, d);
        @(posedge clk);
        #1;
        if (chk) check_regs();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive('0, '0, '0, '0);
        model_reset();
        @(negedge clk);
        #1;
        check("rst_ack",      32'(bus.ack),      0);
        check("rst_reg_ena",  32'(bus.reg_ena),  0);
        check("rst_rd",       32'(bus.rd),       0);
        check("rst_data",     32'(bus.data),     0);
        check("rst_gnt_id",   32'(bus.gnt_id),   0);
        check("rst_wr_count", 32'(bus.wr_count), 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int exp_gnt[6];
        int guard;

        vecs[0] = '{4'b0001, 16'h0005, 32'h0000003C, 4'b0001, 1'b1, 4'h5, 8'h3C, 2'd0, 16'd0};
        vecs[1] = '{4'b0100, 16'h0000, 32'h00770000, 4'b0100, 1'b0, 4'h0, 8'h77, 2'd2, 16'd1};
        vecs[2] = '{4'b0000, 16'h0000, 32'h00000000, 4'b0000, 1'b0, 4'h0, 8'h77, 2'd2, 16'd1};
        vecs[3] = '{4'b1001, 16'hA001, 32'h11000022, 4'b1000, 1'b1, 4'hA, 8'h11, 2'd3, 16'd1};
        vecs[4] = '{4'b1001, 16'hA001, 32'h11000022, 4'b0001, 1'b1, 4'h1, 8'h22, 2'd0, 16'd2};
        vecs[5] = '{4'b0110, 16'h0330, 32'h00554400, 4'b0010, 1'b1, 4'h3, 8'h44, 2'd1, 16'd3};
        vecs[6] = '{4'b0110, 16'h0330, 32'h00554400, 4'b0100, 1'b1, 4'h3, 8'h55, 2'd2, 16'd4};
        vecs[7] = '{4'b0000, 16'h0000, 32'h00000000, 4'b0000, 1'b0, 4'h3, 8'h55, 2'd2, 16'd5};
        vecs[8] = '{4'b0000, 16'h0000, 32'h00000000, 4'b0000, 1'b0, 4'h3, 8'h55, 2'd2, 16'd5};

        drive('0, '0, '0, '0);
        do_reset();

        // Fixed vectors straight out of reset
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].req, 4'b0000, vecs[i].waddr, vecs[i].wdata);
            #1;
            check("tbl_ack", 32'(bus.ack), 32'(vecs[i].ack));
            model_edge(vecs[i].req, 4'b0000, vecs[i].waddr, vecs[i].wdata);
            @(posedge clk);
            #1;
            check("tbl_reg_ena",  32'(bus.reg_ena),  32'(vecs[i].ena));
            check("tbl_rd",       32'(bus.rd),       32'(vecs[i].rd));
            check("tbl_data",     32'(bus.data),     32'(vecs[i].data));
            check("tbl_gnt_id",   32'(bus.gnt_id),   32'(vecs[i].gnt));
            check("tbl_wr_count", 32'(bus.wr_count), 32'(vecs[i].cnt));
            @(negedge clk);
        end

        // All four requesting from reset: strict rotation, 8 commits
        do_reset();
        for (int i = 0; i < 9; i++) begin
            run_cycle(4'b1111, 4'b0000, 16'h4321, 32'hD4C3B2A1, 1'b1);
            if (i < 8) check("rot_gnt", 32'(bus.gnt_id), 32'(i % 4));
        end
        check("rot_count8", 32'(bus.wr_count), 32'd8);

        // Asynchronous reset mid-stream with reg_ena high
        check("pre_rst_ena", 32'(bus.reg_ena), 32'd1);
        #1 reset = 1'b0;
        model_reset();
        #1;
        check("arst_reg_ena",  32'(bus.reg_ena),  0);
        check("arst_rd",       32'(bus.rd),       0);
        check("arst_data",     32'(bus.data),     0);
        check("arst_ack",      32'(bus.ack),      0);
        check("arst_wr_count", 32'(bus.wr_count), 0);
        #1 reset = 1'b1;
        #1;
        check("arst_first_ack", 32'(bus.ack), 32'b0001);
        model_edge(4'b1111, 4'b0000, 16'h4321, 32'hD4C3B2A1);
        @(negedge clk);
        check_regs();

        // Lock sequence: requester 1 locks, requester 3 competes
`ifdef RF_ARB_LOCK_EN
        exp_gnt = '{1, 1, 1, 1, 3, 1};
`else
        exp_gnt = '{1, 3, 1, 3, 1, 3};
`endif
        do_reset();
        for (int i = 0; i < 6; i++) begin
            run_cycle(4'b1010, 4'b0010, 16'h4321, 32'hD4C3B2A1, 1'b1);
            check("lock_gnt", 32'(bus.gnt_id), 32'(exp_gnt[i]));
        end

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            run_cycle(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      16'($urandom), 32'($urandom), 1'b1);
        end

        // wr_count wrap at 0xFFFF
        do_reset();
        guard = 0;
        while (m_cnt != 16'hFFFF && guard < 70000) begin
            run_cycle(4'b1111, 4'b0000, 16'h4321, 32'hD4C3B2A1, 1'b0);
            guard++;
        end
        check("wrap_ffff", 32'(bus.wr_count), 32'h0000FFFF);
        run_cycle(4'b1111, 4'b0000, 16'h4321, 32'hD4C3B2A1, 1'b0);
        check("wrap_zero", 32'(bus.wr_count), 32'h00000000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
